// File: rtl/theremin_pkg.sv
// Shared types and constants for the theremin audio path.
package theremin_pkg;

  localparam int DAC_FRAME_BITS = 24;

  typedef enum logic [1:0] {
    PD_NORMAL   = 2'b00,
    PD_1K       = 2'b01,
    PD_100K     = 2'b10,
    PD_TRISTATE = 2'b11
  } pd_mode_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } dac_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: emits a registered one-cycle pulse every DIV clocks,
// the first one DIV-1 cycles after reset is released.
module tick_gen #(
  parameter int DIV = 1134
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = (cnt == LAST) ? '0 : cnt + CW'(1);
  end

  // The pulse is registered against the next count so it coincides with cnt == LAST.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      tick <= (cnt_nxt == LAST);
    end
  end

endmodule

// File: rtl/dac_spi_tx.sv
// Periodic AD5662-style serializer: captures one sample per tick and shifts a
// 24-bit write frame out with SCLK idling high and data valid on the falling edge.
module dac_spi_tx
  import theremin_pkg::*;
#(
  parameter int SIG_BITS   = 16,
  parameter int SIGNED_IN  = 1,
  parameter int CLK_DIV    = 2,
  parameter int SAMPLE_DIV = 1134
) (
  input  logic                clk_50,
  input  logic                reset,
  input  logic [SIG_BITS-1:0] in_data,
  input  logic [1:0]          pd_mode,
  output logic                sample_tick,
  output logic                busy,
  output logic                dac_sync,
  output logic                dac_din,
  output logic                dac_sclk
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);
  localparam logic [4:0]    SLOT_LAST = 5'(DAC_FRAME_BITS - 1);

  if (SIG_BITS < 1 || SIG_BITS > 16 || CLK_DIV < 1 || SAMPLE_DIV < 48 * CLK_DIV + 2) begin : g_bad_cfg
    $error("dac_spi_tx: illegal SIG_BITS/CLK_DIV/SAMPLE_DIV combination");
  end

  // Left-justify to 16 bits; two's complement becomes offset binary by flipping the MSB.
  function automatic logic [15:0] to_dac_code(input logic [SIG_BITS-1:0] s);
    logic [15:0] c;
    c = 16'(s) << (16 - SIG_BITS);
    if (SIGNED_IN != 0) c[15] = ~c[15];
    return c;
  endfunction

  dac_state_t                    state;
  logic [HW-1:0]                 hcnt;
  logic [4:0]                    slot;
  logic                          second_half;
  logic [DAC_FRAME_BITS-1:0]     shreg;
  logic [DAC_FRAME_BITS-1:0]     frame_nxt;

  assign frame_nxt = {6'b0, pd_mode, to_dac_code(in_data)};

  tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
    .clk  (clk_50),
    .rst  (reset),
    .tick (sample_tick)
  );

  // shreg holds data only and is reloaded on every tick, so it carries no reset.
  always_ff @(posedge clk_50) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      dac_sync    <= 1'b1;
      dac_sclk    <= 1'b1;
      dac_din     <= 1'b0;
      hcnt        <= '0;
      slot        <= '0;
      second_half <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sample_tick) begin
            state       <= SHIFT;
            busy        <= 1'b1;
            dac_sync    <= 1'b0;
            dac_sclk    <= 1'b1;
            dac_din     <= frame_nxt[DAC_FRAME_BITS-1];
            shreg       <= {frame_nxt[DAC_FRAME_BITS-2:0], 1'b0};
            hcnt        <= '0;
            slot        <= '0;
            second_half <= 1'b0;
          end
        end
        SHIFT: begin
          if (hcnt != HALF_LAST) begin
            hcnt <= hcnt + HW'(1);
          end else begin
            hcnt <= '0;
            if (!second_half) begin
              second_half <= 1'b1;
              dac_sclk    <= 1'b0;
            end else begin
              // Slot boundary: SCLK rises and the next bit is presented together.
              second_half <= 1'b0;
              dac_sclk    <= 1'b1;
              if (slot == SLOT_LAST) begin
                state    <= IDLE;
                busy     <= 1'b0;
                dac_sync <= 1'b1;
                dac_din  <= 1'b0;
              end else begin
                slot    <= slot + 5'd1;
                dac_din <= shreg[DAC_FRAME_BITS-1];
                shreg   <= {shreg[DAC_FRAME_BITS-2:0], 1'b0};
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Bench for dac_spi_tx: a DAC-side model decodes the wire and results are
// compared to frames computed arithmetically from the sample and power-down bits.
module tb_dac_spi_tx;
  import theremin_pkg::*;

  localparam int SDIV  = 1134;
  localparam int BOUND = 4 * SDIV;

  logic clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic        reset   = 1'b1;
  logic [15:0] in_data = '0;
  logic [1:0]  pd_mode = '0;
  logic        sample_tick, busy, dac_sync, dac_din, dac_sclk;

  logic [11:0] b_in = '0;
  logic [1:0]  b_pd = '0;
  logic        b_tick, b_busy, b_sync, b_din, b_sclk;

  int n_cmp = 0;
  int n_bad = 0;

  dac_spi_tx dut (
    .clk_50(clk_50), .reset(reset), .in_data(in_data), .pd_mode(pd_mode),
    .sample_tick(sample_tick), .busy(busy), .dac_sync(dac_sync),
    .dac_din(dac_din), .dac_sclk(dac_sclk)
  );

  dac_spi_tx #(.SIG_BITS(12), .SIGNED_IN(0), .CLK_DIV(1), .SAMPLE_DIV(50)) dut_u12 (
    .clk_50(clk_50), .reset(reset), .in_data(b_in), .pd_mode(b_pd),
    .sample_tick(b_tick), .busy(b_busy), .dac_sync(b_sync),
    .dac_din(b_din), .dac_sclk(b_sclk)
  );

  // Expected frame: sample left-justified to 16 bits, offset by half scale if signed.
  function automatic logic [23:0] ref_frame(input int unsigned sample, input int bits,
                                            input bit signed_in, input logic [1:0] pd);
    int unsigned code;
    code = sample << (16 - bits);
    if (signed_in) code = (code + 32768) % 65536;
    return {6'b0, pd, code[15:0]};
  endfunction

  // DAC-side model of the main instance, sampled mid-cycle.
  logic        prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0;
  logic [23:0] mon_bits = '0, mon_last_frame = '0;
  int mon_nfall = 0, mon_low = 0, mon_last_nfall = 0, mon_last_low = 0;
  int mon_done = 0, mon_good = 0, mon_aborts = 0;
  int din_bad = 0, busy_bad = 0, idle_bad = 0;

  always @(negedge clk_50) begin
    if (dac_sync === 1'b0) begin
      if (prev_sync === 1'b1) begin
        mon_bits  = '0;
        mon_nfall = 0;
        mon_low   = 0;
      end
      mon_low++;
      if (prev_sclk === 1'b1 && dac_sclk === 1'b0) begin
        mon_bits = {mon_bits[22:0], dac_din};
        mon_nfall++;
      end
    end else begin
      if (dac_sclk !== 1'b1 || dac_din !== 1'b0) idle_bad++;
      if (prev_sync === 1'b0) begin
        mon_last_frame = mon_bits;
        mon_last_nfall = mon_nfall;
        mon_last_low   = mon_low;
        mon_done++;
        if (mon_nfall == 24) mon_good++;
        else mon_aborts++;
      end
    end
    if (busy !== ~dac_sync) busy_bad++;
    if (dac_din !== prev_din && !(prev_sclk === 1'b0 && dac_sclk === 1'b1) && dac_sync === prev_sync)
      din_bad++;
    prev_sync = dac_sync;
    prev_sclk = dac_sclk;
    prev_din  = dac_din;
  end

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      @(posedge clk_50); #1;
      n++;
    end while (sample_tick !== 1'b1 && n < BOUND);
  endtask

  task automatic wait_frame(output bit ok);
    int d0;
    d0 = mon_done;
    ok = 1'b0;
    for (int c = 0; c < BOUND; c++) begin
      @(posedge clk_50); #1;
      if (mon_done != d0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_50); #1;
      n_cmp++;
      if ({sample_tick, busy, dac_sync, dac_sclk, dac_din} !== 5'b00110) begin
        n_bad++;
        $display("FAIL reset_outputs cycle %0d: got %b want 00110", i,
                 {sample_tick, busy, dac_sync, dac_sclk, dac_din});
      end
    end
    reset = 1'b0;
    wait_tick(n);
    n_cmp++;
    if (n != SDIV - 1) begin
      n_bad++;
      $display("FAIL first_tick: got %0d cycles want %0d", n, SDIV - 1);
    end
    wait_tick(n);
    n_cmp++;
    if (n != SDIV) begin
      n_bad++;
      $display("FAIL tick_period: got %0d cycles want %0d", n, SDIV);
    end
  endtask

  task automatic test_code_conversion();
    logic [15:0] vals[8];
    logic [1:0]  pds[8];
    logic [23:0] exp_f;
    int n;
    bit ok;
    vals[0] = 16'h0000; pds[0] = PD_NORMAL;
    vals[1] = 16'h7FFF; pds[1] = PD_NORMAL;
    vals[2] = 16'h8000; pds[2] = PD_NORMAL;
    vals[3] = 16'h1234; pds[3] = PD_TRISTATE;
    for (int i = 4; i < 8; i++) begin
      vals[i] = 16'($urandom);
      pds[i]  = 2'($urandom);
    end
    for (int i = 0; i < 8; i++) begin
      in_data = vals[i];
      pd_mode = pds[i];
      exp_f = ref_frame(32'(vals[i]), 16, 1'b1, pds[i]);
      wait_tick(n);
      wait_frame(ok);
      n_cmp++;
      if (!ok || mon_last_nfall != 24 || mon_last_frame !== exp_f) begin
        n_bad++;
        $display("FAIL frame[%0d] in=%h pd=%b: got %h (%0d falls, done=%0b) want %h (24 falls)",
                 i, vals[i], pds[i], mon_last_frame, mon_last_nfall, ok, exp_f);
      end
      n_cmp++;
      if (mon_last_low != 48 * 2) begin
        n_bad++;
        $display("FAIL sync_low[%0d]: got %0d cycles want %0d", i, mon_last_low, 96);
      end
    end
  endtask

  task automatic test_input_toggle();
    logic [15:0] x;
    logic [1:0]  p;
    logic [23:0] exp_f;
    int n, d0, bad0;
    x = 16'($urandom);
    p = 2'($urandom);
    in_data = x;
    pd_mode = p;
    exp_f = ref_frame(32'(x), 16, 1'b1, p);
    bad0 = din_bad;
    wait_tick(n);
    d0 = mon_done;
    repeat (110) begin
      @(posedge clk_50); #1;
      in_data = 16'($urandom);
      pd_mode = 2'($urandom);
    end
    n_cmp++;
    if (mon_done == d0 || mon_last_frame !== exp_f) begin
      n_bad++;
      $display("FAIL toggle_frame: got %h want %h", mon_last_frame, exp_f);
    end
    n_cmp++;
    if (din_bad != bad0) begin
      n_bad++;
      $display("FAIL din_edge: got %0d off-edge changes want 0", din_bad - bad0);
    end
    n_cmp++;
    if (busy_bad != 0 || idle_bad != 0) begin
      n_bad++;
      $display("FAIL busy_idle: got busy_bad=%0d idle_bad=%0d want 0/0", busy_bad, idle_bad);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] y;
    logic [23:0] exp_f;
    int n, c, g0, a0;
    bit ok;
    in_data = 16'($urandom);
    pd_mode = PD_NORMAL;
    wait_tick(n);
    g0 = mon_good;
    a0 = mon_aborts;
    c = 0;
    while (mon_nfall != 10 && c < 200) begin
      @(posedge clk_50); #1;
      c++;
    end
    n_cmp++;
    if (mon_nfall != 10) begin
      n_bad++;
      $display("FAIL abort_reach10: got %0d falls want 10", mon_nfall);
    end
    y = 16'($urandom);
    reset = 1'b1;
    @(posedge clk_50); #1;
    n_cmp++;
    if ({dac_sync, dac_sclk, busy, dac_din} !== 4'b1100) begin
      n_bad++;
      $display("FAIL abort_idle: got %b want 1100", {dac_sync, dac_sclk, busy, dac_din});
    end
    reset   = 1'b0;
    in_data = y;
    wait_tick(n);
    n_cmp++;
    if (n != SDIV - 1) begin
      n_bad++;
      $display("FAIL abort_retick: got %0d cycles want %0d", n, SDIV - 1);
    end
    n_cmp++;
    if (mon_aborts != a0 + 1 || mon_good != g0) begin
      n_bad++;
      $display("FAIL abort_report: got aborts+%0d good+%0d want aborts+1 good+0",
               mon_aborts - a0, mon_good - g0);
    end
    exp_f = ref_frame(32'(y), 16, 1'b1, 2'b00);
    wait_frame(ok);
    n_cmp++;
    if (!ok || mon_last_nfall != 24 || mon_last_frame !== exp_f) begin
      n_bad++;
      $display("FAIL abort_resume: got %h (%0d falls) want %h", mon_last_frame, mon_last_nfall, exp_f);
    end
  endtask

  task automatic test_unsigned12();
    logic [11:0] vals[3];
    logic [1:0]  pds[3];
    logic [23:0] f, exp_f;
    int c, nf, low;
    bit prev_s, busy_ok;
    vals[0] = 12'hABC;        pds[0] = PD_NORMAL;
    vals[1] = 12'($urandom);  pds[1] = 2'($urandom);
    vals[2] = 12'($urandom);  pds[2] = 2'($urandom);
    for (int i = 0; i < 3; i++) begin
      b_in = vals[i];
      b_pd = pds[i];
      exp_f = ref_frame(32'(vals[i]), 12, 1'b0, pds[i]);
      c = 0;
      do begin
        @(posedge clk_50); #1;
        c++;
      end while (b_tick !== 1'b1 && c < 200);
      f = '0; nf = 0; low = 0; prev_s = 1'b1; busy_ok = 1'b1;
      @(posedge clk_50); #1;
      while (b_sync === 1'b0 && low < 200) begin
        low++;
        if (b_busy !== 1'b1) busy_ok = 1'b0;
        if (prev_s && b_sclk === 1'b0) begin
          f = {f[22:0], b_din};
          nf++;
        end
        prev_s = b_sclk;
        @(posedge clk_50); #1;
      end
      n_cmp++;
      if (f !== exp_f || nf != 24 || !busy_ok || b_busy !== 1'b0) begin
        n_bad++;
        $display("FAIL u12_frame[%0d] in=%h: got %h (%0d falls, busy_ok=%0b) want %h",
                 i, vals[i], f, nf, busy_ok, exp_f);
      end
      n_cmp++;
      if (low != 48) begin
        n_bad++;
        $display("FAIL u12_sync_low[%0d]: got %0d cycles want 48", i, low);
      end
    end
  endtask

  initial begin
    test_reset();
    test_code_conversion();
    test_input_toggle();
    test_reset_abort();
    test_unsigned12();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
